// File: rtl/sub_pipe_pkg.sv
// Shared constants and helpers for the pipelined subtractor.
package sub_pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/sub_pipe_if.sv
// Operand/result stream bundle: producer side drives operands and consumes results.
interface sub_pipe_if
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             carry_out;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, diff, carry_out
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, diff, carry_out
  );

endinterface

// File: rtl/sub_pipe_chunk.sv
// One combinational slice of the borrow chain: a + ~b + c_in over CHUNK bits.
module sub_chunk
  import sub_pipe_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             c_in,
  output logic [CHUNK-1:0] d_s,
  output logic             c_out
);

  logic [CHUNK:0] sum_s;

  // Widen by one bit so the slice carry lands in the MSB.
  always_comb begin
    sum_s = {1'b0, a_s} + {1'b0, ~b_s} + {{CHUNK{1'b0}}, c_in};
  end

  assign d_s   = sum_s[CHUNK-1:0];
  assign c_out = sum_s[CHUNK];

endmodule

// File: rtl/sub_pipe.sv
// Pipelined unsigned subtractor, one CHUNK-bit slice resolved per stage,
// valid/ready on both sides with a whole-pipe stall under backpressure.
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_pipe_if.slave   bus
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("sub_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic adv_s;

  assign adv_s        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv_s;

  // Stage k resolves slice k; SRC_W is the operand part still unconsumed on entry,
  // REM_W what is skewed forward, RES_W the diff bits resolved so far.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * CHUNK;
    localparam int REM_W = SRC_W - CHUNK;
    localparam int RES_W = (k + 1) * CHUNK;

    logic [SRC_W-1:0] a_src_s;
    logic [SRC_W-1:0] b_src_s;
    logic             c_src_s;
    logic             v_src_s;
    logic [CHUNK-1:0] slice_d_s;
    logic             slice_c_s;
    logic [RES_W-1:0] d_d;
    logic [RES_W-1:0] d_q;
    logic             c_q;
    logic             vld_q;

    if (k == 0) begin : g_head
      assign a_src_s = bus.a;
      assign b_src_s = bus.b;
      assign c_src_s = bus.cin;
      assign v_src_s = bus.in_valid;
      assign d_d     = slice_d_s;
    end else begin : g_body
      assign a_src_s = g_stage[k-1].g_skew.a_q;
      assign b_src_s = g_stage[k-1].g_skew.b_q;
      assign c_src_s = g_stage[k-1].c_q;
      assign v_src_s = g_stage[k-1].vld_q;
      assign d_d     = {slice_d_s, g_stage[k-1].d_q};
    end

    sub_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_s   (a_src_s[CHUNK-1:0]),
      .b_s   (b_src_s[CHUNK-1:0]),
      .c_in  (c_src_s),
      .d_s   (slice_d_s),
      .c_out (slice_c_s)
    );

    // Valid always shifts on advance; data only loads behind a real pair so
    // the output stays zero until the first result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        d_q   <= {RES_W{1'b0}};
      end else if (adv_s) begin
        vld_q <= v_src_s;
        if (v_src_s) begin
          c_q <= slice_c_s;
          d_q <= d_d;
        end
      end
    end

    if (REM_W > 0) begin : g_skew
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      // Skew registers carry the not-yet-used upper operand slices.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= {REM_W{1'b0}};
          b_q <= {REM_W{1'b0}};
        end else if (adv_s && v_src_s) begin
          a_q <= a_src_s[SRC_W-1:CHUNK];
          b_q <= b_src_s[SRC_W-1:CHUNK];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.diff      = g_stage[STAGES-1].d_q;
  assign bus.carry_out = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Directed + random scoreboard bench for sub_pipe (WIDTH=16, CHUNK=4).
module tb_sub_pipe;
  import sub_pipe_pkg::*;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int LAT = W / C;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sub_pipe_if #(.WIDTH(W)) bus ();

  sub_pipe #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  int           n_out    = 0;
  logic [W:0]   sb [$];
  logic [W:0]   exp_in;
  bit           stall_prev = 1'b0;
  logic [W:0]   stall_val;

  // Reference: 17-bit subtraction, bit W set means a borrow came out.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    logic [W:0] full;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ~cin};
    return {~full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_pair();
    bus.a   = 16'($urandom);
    bus.b   = 16'($urandom);
    bus.cin = 1'($urandom_range(0, 1));
    exp_in  = model(bus.a, bus.b, bus.cin);
  endtask

  // One clock: settle, score the transfers that happen at the coming edge, advance.
  task automatic cycle(output bit acc);
    logic [W:0] exp;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && !bus.out_ready) begin
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      if (stall_prev) check("stall_stable", {15'b0, bus.carry_out, bus.diff}, {15'b0, stall_val});
      stall_prev = 1'b1;
      stall_val  = {bus.carry_out, bus.diff};
    end else begin
      stall_prev = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      check("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("result", {15'b0, bus.carry_out, bus.diff}, {15'b0, exp});
      end
    end
    if (acc) sb.push_back(exp_in);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W:0] exp);
    bit acc;
    int g;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    exp_in       = exp;
    bus.in_valid = 1'b1;
    g = 0;
    do begin
      cycle(acc);
      g++;
    end while (!acc && g < 20);
    bus.in_valid = 1'b0;
    check("send_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain(input string tag);
    bit acc;
    int g;
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      cycle(acc);
      g++;
    end
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    bit acc;
    int lat;
    int sent;
    int n0;
    int calls;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    exp_in        = 17'h0;

    #2;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_diff", {16'b0, bus.diff}, 32'd0);
    check("rst_carry", {31'b0, bus.carry_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_rst_diff", {16'b0, bus.diff}, 32'd0);

    // First pair and its latency
    send(16'h1234, 16'h0034, 1'b1, {1'b1, 16'h1200});
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle(acc);
      lat++;
    end
    check("latency", lat, LAT);
    drain("drain_first");

    // Wrap-around, equal with borrow, cross-slice borrow ripple
    send(16'h0002, 16'h0005, 1'b1, {1'b0, 16'hFFFD});
    send(16'h0003, 16'h0003, 1'b0, {1'b0, 16'hFFFF});
    send(16'h1000, 16'h0001, 1'b1, {1'b1, 16'h0FFF});
    send(16'h0000, 16'h0000, 1'b0, {1'b0, 16'hFFFF});
    send(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'h0000});
    drain("drain_directed");

    // Backpressure: 8 pairs back-to-back, consumer stalled on cycles 5..9
    n0   = n_out;
    sent = 0;
    rand_pair();
    for (int t = 0; t < 60 && (sent < 8 || sb.size() != 0); t++) begin
      bus.out_ready = !(t >= 5 && t <= 9);
      bus.in_valid  = (sent < 8);
      cycle(acc);
      if (acc) begin
        sent++;
        rand_pair();
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_sent", sent, 32'd8);
    check("bp_results", n_out - n0, 32'd8);
    check("bp_sb_empty", sb.size(), 32'd0);

    // Full throughput: 100 random pairs, one per cycle
    n0    = n_out;
    calls = 0;
    bus.in_valid = 1'b1;
    rand_pair();
    for (int i = 0; i < 100; i++) begin
      cycle(acc);
      calls++;
      check("tp_accept", {31'b0, acc}, 32'd1);
      rand_pair();
    end
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && calls < 200) begin
      cycle(acc);
      calls++;
    end
    check("tp_results", n_out - n0, 32'd100);
    check("tp_cycles", calls, 32'd100 + LAT);

    // Reset with pairs in flight and a result on the output
    bus.in_valid = 1'b1;
    rand_pair();
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      rand_pair();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_diff", {16'b0, bus.diff}, 32'd0);
    check("mid_rst_carry", {31'b0, bus.carry_out}, 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_out_valid", {31'b0, bus.out_valid}, 32'd0);
    n0 = n_out;
    send(16'hABCD, 16'h1234, 1'b0, {1'b1, 16'h9998});
    drain("drain_after_rst");
    for (int i = 0; i < 6; i++) cycle(acc);
    check("after_rst_results", n_out - n0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
- Parametrised, pipelined unsigned subtractor that succeeds the fixed 4-bit combinational subtractor.
- Computes diff = a - b - (1 - cin) over WIDTH bits. carry_out = 1 means no borrow, i.e. a >= b + (1 - cin).
- The carry chain is split into CHUNK-bit slices, one slice per register stage, so wide operands meet timing.
- Uses a valid/ready handshake on both sides with full backpressure. It sits in datapaths that stream operand pairs.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK and >= CHUNK.
- CHUNK, 4: bits resolved per pipeline stage. STAGES = WIDTH / CHUNK.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair a, b, cin presented.
- in_ready  out  1  block accepts the operand pair this cycle.
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- cin  in  1  carry in: 1 = no borrow in, 0 = borrow 1.
- out_valid  out  1  result held on diff/carry_out.
- out_ready  in  1  consumer takes the result this cycle.
- diff  out  WIDTH  (a - b - !cin) mod 2^WIDTH.
- carry_out  out  1  1 when a >= b + !cin, 0 otherwise.

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit and every pipeline data register. out_valid=0, diff=0, carry_out=0 while rst_n is low and until the first result leaves the pipe.
- Reset mid-operation discards all in-flight pairs. No partial result ever appears at the output.
- Arithmetic: slice k, for k = 0..STAGES-1, computes a[k] + ~b[k] + c_k, where c_0 = cin. The carry from slice k registers into stage k+1.
- Skew registers: each stage carries the not-yet-used upper slices of a and b forward, plus the already-resolved lower diff slices.
- After the last stage, carry_out is the final slice carry.
- Handshake: adv = !out_valid || out_ready. in_ready = adv, and it is a purely combinational function of out_valid and out_ready.
- Acceptance: a transfer is accepted when in_valid && in_ready.
- When adv=1, all stages shift one place: stage 0 loads the accepted pair, and its valid bit = in_valid.
- When adv=0, all stages hold. Bubbles are not compressed.
- Latency: STAGES cycles from acceptance to out_valid, given out_ready held high.
- Throughput: 1 result per cycle with out_ready held high.
- Output stability: while out_valid=1 && out_ready=0, diff and carry_out stay stable.
- Simultaneous events: out_ready=1 together with in_valid=1 on the same edge retires one result and accepts one pair.
- in_valid=0 while adv=1 inserts a bubble, which shifts through like data.
- Wrap-around: a < b gives the 2^WIDTH modular difference with carry_out=0. a = b with cin=0 gives all-ones with carry_out=0.
- Degenerate case: CHUNK = WIDTH gives STAGES = 1, i.e. one registered stage, latency 1.
- Elaboration must fail (assertion) if WIDTH % CHUNK != 0.

Decomposition:
- Package sub_pipe_pkg holds the default constants DEFAULT_WIDTH=16 and DEFAULT_CHUNK=4.
- sub_pipe_pkg also holds the function num_stages(width, chunk), which returns width/chunk.
- Sub-module sub_chunk (parameter CHUNK): combinational slice.
  - Inputs: a_s, b_s, c_in.
  - Outputs: d_s, c_out.
  - It computes a_s + ~b_s + c_in.
- sub_pipe instantiates STAGES copies of sub_chunk in a generate loop, together with the stage registers.

Test Plan (WIDTH=16, CHUNK=4, so latency 4; the bench checks every result against a - b - !cin and a >= b + !cin):
- Reset, then a=0x1234, b=0x0034, cin=1, out_ready=1 -> out_valid rises 4 cycles after acceptance, diff=0x1200, carry_out=1.
- a=0x0002, b=0x0005, cin=1 -> diff=0xFFFD, carry_out=0. a=0x0003, b=0x0003, cin=0 -> diff=0xFFFF, carry_out=0.
- Cross-slice borrow: a=0x1000, b=0x0001, cin=1 -> diff=0x0FFF, carry_out=1, with the borrow rippling through all 4 stages.
- Backpressure: stream 8 pairs back-to-back, holding out_ready=0 for cycles 5-9.
  - in_ready must be 0 while out_valid=1 && out_ready=0.
  - diff must be stable during the stall.
  - All 8 results must arrive in order, none lost or duplicated.
- Full throughput: 100 random pairs with in_valid=1 and out_ready=1 -> 100 results, one per cycle after a 4-cycle fill, all matching the model.
- Reset mid-stream: pull rst_n low with 3 pairs in flight -> out_valid=0, diff=0 immediately, without waiting for a clock edge. After release, the first new pair's result is the first output seen.
